// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider.
//   DefaultWidth : default operand width, kept equal to booth_multiplier's default
//                  so the two blocks agree when instantiated side by side.
//   div_state_e  : FSM state encoding of the divider controller.
package seq_signed_divider_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StCalc     = 2'd1,
        StFix      = 2'd2,
        StLoadZero = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_signed_divider_div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports:
//   prem      in  N+1  partial remainder before this step
//   next_bit  in  1    next dividend bit shifted in at the bottom
//   dvs_mag   in  N    divisor magnitude
//   prem_next out N+1  partial remainder after this step
//   q_bit     out 1    quotient bit produced by this step
module div_restore_step
    import seq_signed_divider_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input  logic [N:0]   prem,
    input  logic         next_bit,
    input  logic [N-1:0] dvs_mag,
    output logic [N:0]   prem_next,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    always_comb begin
        shifted   = {prem, next_bit};
        // One extra bit of headroom so the borrow lands in trial[N+1].
        trial     = shifted - {2'b00, dvs_mag};
        q_bit     = ~trial[N+1];
        prem_next = q_bit ? trial[N:0] : shifted[N:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit
// per clock, then a sign fix-up so that quotient*divisor + remainder == dividend.
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   start        request, sampled only when idle
//   dividend     signed dividend, sampled at the start edge
//   divisor      signed divisor, sampled at the start edge
//   busy         operation in flight
//   done         one-cycle pulse, results valid in that cycle
//   quotient     signed quotient, truncated toward zero (held until next done)
//   remainder    signed remainder, sign of the dividend (held until next done)
//   div_by_zero  with done: divisor was zero
//   overflow     with done: operands were (-2^(N-1), -1)
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int unsigned CntW = $clog2(N + 1);

    div_state_e     state_q;
    logic [N-1:0]   a_q;        // dividend magnitude, becomes the quotient magnitude
    logic [N-1:0]   b_q;        // divisor magnitude
    logic [N:0]     p_q;        // partial remainder
    logic [CntW-1:0] cnt_q;
    logic           neg_quot_q;
    logic           neg_rem_q;
    logic           ovf_case_q;

    logic [N-1:0]   dvd_mag;
    logic [N-1:0]   dvs_mag;
    logic           dvd_is_min;
    logic           dvs_is_neg1;
    logic [N:0]     step_rem;
    logic           step_q;

    // |-2^(N-1)| = 2^(N-1) still fits as an unsigned N-bit magnitude.
    always_comb begin
        dvd_mag     = dividend[N-1] ? -dividend : dividend;
        dvs_mag     = divisor[N-1] ? -divisor : divisor;
        dvd_is_min  = (dividend == {1'b1, {(N-1){1'b0}}});
        dvs_is_neg1 = &divisor;
    end

    div_restore_step #(
        .N (N)
    ) u_step (
        .prem      (p_q),
        .next_bit  (a_q[N-1]),
        .dvs_mag   (b_q),
        .prem_next (step_rem),
        .q_bit     (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_case_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q        <= dvd_mag;
                        b_q        <= dvs_mag;
                        p_q        <= '0;
                        cnt_q      <= CntW'(N);
                        neg_quot_q <= dividend[N-1] ^ divisor[N-1];
                        neg_rem_q  <= dividend[N-1];
                        ovf_case_q <= dvd_is_min & dvs_is_neg1;
                        busy       <= 1'b1;
                        state_q    <= (divisor == '0) ? StLoadZero : StCalc;
                    end
                end
                StCalc: begin
                    p_q   <= step_rem;
                    a_q   <= {a_q[N-2:0], step_q};
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    // Overflow case needs no special path: q_mag = 2^(N-1) with a
                    // positive sign already reads back as -2^(N-1).
                    quotient  <= neg_quot_q ? -a_q : a_q;
                    remainder <= neg_rem_q ? -p_q[N-1:0] : p_q[N-1:0];
                    overflow  <= ovf_case_q;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                StLoadZero: begin
                    // Rebuild the signed dividend from its latched magnitude and sign.
                    quotient    <= '1;
                    remainder   <= neg_rem_q ? -a_q : a_q;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multi-cycle signed integer divider: the inverse operation of the team's combinational signed Booth multiplier.
- Computes quotient and remainder of two N-bit two's-complement operands using restoring division on magnitudes, one quotient bit per clock, followed by a sign fix-up.
- Uses a start/done handshake so it can sit behind a controller that also drives booth_multiplier.
- Results satisfy quotient*divisor + remainder == dividend, so they round-trip through booth_multiplier.

Parameters:
- N, 4, operand width in bits (N >= 2); quotient and remainder are also N bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N  signed dividend; sampled at the start edge only.
- divisor  input  N  signed divisor; sampled at the start edge only.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; results valid in that cycle.
- quotient  output  N  signed quotient, truncated toward zero.
- remainder  output  N  signed remainder; sign follows the dividend.
- div_by_zero  output  1  set with done when divisor == 0.
- overflow  output  1  set with done when dividend == -2^(N-1) and divisor == -1.

Behaviour:
- Reset (async, any state, including mid-operation) forces the following; any in-flight operation is discarded.
  - State goes to IDLE.
  - busy, done, div_by_zero, overflow = 0.
  - quotient = 0, remainder = 0.
  - Internal registers are cleared.
- States:
  - IDLE -> LOAD_ZERO on a start edge when divisor == 0.
  - IDLE -> CALC on a start edge otherwise.
  - CALC -> FIX after N steps.
  - FIX -> IDLE.
  - LOAD_ZERO -> IDLE.
- Start edge (edge k, in IDLE with start = 1):
  - Latch |dividend| and |divisor| as unsigned N-bit magnitudes. |-2^(N-1)| = 2^(N-1) fits in N bits unsigned.
  - Latch sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Clear the partial remainder (N+1 bits).
  - Load step counter = N.
  - busy = 1.
- CALC (edges k+1 .. k+N), one restoring step per edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the trial result is non-negative, keep it and shift in quotient bit 1; otherwise keep the old value and shift in 0.
  - Decrement the counter; leave CALC when the counter reaches 0.
- FIX (edge k+N+1):
  - quotient = sign_q ? -q_mag : q_mag, truncated to N bits.
  - remainder = sign_r ? -r_mag : r_mag.
  - done = 1, busy = 0.
  - overflow = 1 iff the latched operands were (-2^(N-1), -1). In that case the quotient wraps to -2^(N-1) and the remainder is 0.
- Latency: done is high in the cycle after edge k+N+1, i.e. N+2 edges after start is sampled. Throughput is one operation per N+2 cycles.
- LOAD_ZERO (edge k+1): done = 1, div_by_zero = 1, quotient = all ones (-1), remainder = dividend, busy = 0.
- done and both flags last exactly one cycle. quotient and remainder hold their values until the next done or reset.
- start while busy is ignored, not queued. Input changes after the start edge have no effect.
- start held high continuously: a new operation begins on the edge after done (back in IDLE).
- Zero dividend: quotient = 0, remainder = 0, normal N+2 latency.

Decomposition:
- Shared header/package holds:
  - state encodings IDLE, CALC, FIX, LOAD_ZERO (2 bits);
  - default width constant N = 4, shared with booth_multiplier so both blocks agree on the default width.
- One sub-module, div_restore_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - The FSM, counter and sign logic stay in the top level.

Test Plan:
- dividend = -7, divisor = 2 -> after N+2 edges: done = 1, quotient = -3, remainder = -1, both flags 0.
- dividend = 7, divisor = -3 -> quotient = -2, remainder = 1; then dividend = 6, divisor = 3 -> quotient = 2, remainder = 0.
- dividend = -8, divisor = -1 (N = 4) -> quotient = -8, remainder = 0, overflow = 1. Also dividend = 5, divisor = 0 -> done after 2 edges, div_by_zero = 1, quotient = -1, remainder = 5.
- start = 1 with (3, 1), then pulse start with (7, 7) while busy -> the second request is ignored; done = 1 once, quotient = 3, remainder = 0.
- Assert rst at CALC step 2 -> outputs and busy go to 0 immediately without waiting for a clock edge; no done. A fresh start with (-6, 4) then gives quotient = -1, remainder = -2.
- Exhaustive N = 4 sweep, all dividends x nonzero divisors excluding (-8, -1):
  - feed quotient and divisor into booth_multiplier and check product + remainder == dividend;
  - check |remainder| < |divisor|;
  - check the remainder sign matches the dividend, or the remainder is 0.
